// File: rtl/dma_axi_w_burst.sv
// rtl/dma_axi_w_burst.sv - AXI4 write-channel DMA master
// Splits a beat stream into INCR bursts limited by MAX_BURST_LEN and 4 KB pages.
module dma_axi_w_burst #(
  parameter int DMA_DATA_W    = 32,
  parameter int ADDR_W        = 32,
  parameter int XFER_W        = 16,
  parameter int MAX_BURST_LEN = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_i,
  input  logic [ADDR_W-1:0]       start_addr_i,
  input  logic [XFER_W-1:0]       xfer_beats_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    error_o,
  input  logic                    s_valid_i,
  input  logic [DMA_DATA_W-1:0]   s_data_i,
  input  logic [DMA_DATA_W/8-1:0] s_strb_i,
  output logic                    s_ready_o,
  output logic [3:0]              m_axi_awid_o,
  output logic [ADDR_W-1:0]       m_axi_awaddr_o,
  output logic [7:0]              m_axi_awlen_o,
  output logic [2:0]              m_axi_awsize_o,
  output logic [1:0]              m_axi_awburst_o,
  output logic                    m_axi_awlock_o,
  output logic [3:0]              m_axi_awcache_o,
  output logic [2:0]              m_axi_awprot_o,
  output logic [3:0]              m_axi_awqos_o,
  output logic                    m_axi_awvalid_o,
  input  logic                    m_axi_awready_i,
  output logic [DMA_DATA_W-1:0]   m_axi_wdata_o,
  output logic [DMA_DATA_W/8-1:0] m_axi_wstrb_o,
  output logic                    m_axi_wlast_o,
  output logic                    m_axi_wvalid_o,
  input  logic                    m_axi_wready_i,
  input  logic [1:0]              m_axi_bresp_i,
  input  logic                    m_axi_bvalid_i,
  output logic                    m_axi_bready_o
);

  localparam int BYTES = DMA_DATA_W / 8;
  localparam int SIZE  = $clog2(BYTES);
  localparam int CW    = (XFER_W > 13) ? XFER_W : 13;

  typedef enum logic [2:0] {S_IDLE, S_CALC, S_ADDR, S_DATA, S_RESP} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [XFER_W-1:0]   rem_q, rem_d;
  logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
  logic [7:0]          awlen_q, awlen_d;
  logic [8:0]          blen_q, blen_d;
  logic [7:0]          beat_cnt_q, beat_cnt_d;
  logic                error_q, error_d;
  logic                done_q, done_d;

  logic [12:0]         page_beats;
  logic [CW-1:0]       cand;
  logic [8:0]          blen_calc;
  logic                w_hs;

  // Burst length is the smallest of what is left, the burst cap and the room to the 4 KB edge.
  always_comb begin
    page_beats = 13'((13'd4096 - {1'b0, addr_q[11:0]}) >> SIZE);
    cand       = CW'(rem_q);
    if (cand > CW'(MAX_BURST_LEN)) cand = CW'(MAX_BURST_LEN);
    if (cand > CW'(page_beats))    cand = CW'(page_beats);
    blen_calc  = cand[8:0];
  end

  assign w_hs = (state_q == S_DATA) && s_valid_i && m_axi_wready_i;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    awaddr_d   = awaddr_q;
    awlen_d    = awlen_q;
    blen_d     = blen_q;
    beat_cnt_d = beat_cnt_q;
    error_d    = error_q;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          error_d = 1'b0;
          if (xfer_beats_i != '0) begin
            addr_d  = start_addr_i;
            rem_d   = xfer_beats_i;
            state_d = S_CALC;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_CALC: begin
        awaddr_d = addr_q;
        awlen_d  = 8'(blen_calc - 9'd1);
        blen_d   = blen_calc;
        state_d  = S_ADDR;
      end
      S_ADDR: begin
        if (m_axi_awready_i) begin
          beat_cnt_d = awlen_q;
          state_d    = S_DATA;
        end
      end
      S_DATA: begin
        if (w_hs) begin
          if (beat_cnt_q == 8'd0) begin
            addr_d  = addr_q + (ADDR_W'(blen_q) << SIZE);
            rem_d   = rem_q - XFER_W'(blen_q);
            state_d = S_RESP;
          end else begin
            beat_cnt_d = beat_cnt_q - 8'd1;
          end
        end
      end
      S_RESP: begin
        if (m_axi_bvalid_i) begin
          error_d = error_q | (m_axi_bresp_i != 2'b00);
          if (rem_q == '0) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_CALC;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      awaddr_q   <= '0;
      awlen_q    <= '0;
      blen_q     <= '0;
      beat_cnt_q <= '0;
      error_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      awaddr_q   <= awaddr_d;
      awlen_q    <= awlen_d;
      blen_q     <= blen_d;
      beat_cnt_q <= beat_cnt_d;
      error_q    <= error_d;
      done_q     <= done_d;
    end
  end

  assign busy_o  = (state_q != S_IDLE);
  assign done_o  = done_q;
  assign error_o = error_q;

  assign m_axi_awid_o    = 4'd0;
  assign m_axi_awaddr_o  = awaddr_q;
  assign m_axi_awlen_o   = awlen_q;
  assign m_axi_awsize_o  = 3'(SIZE);
  assign m_axi_awburst_o = 2'b01;
  assign m_axi_awlock_o  = 1'b0;
  assign m_axi_awcache_o = 4'b0010;
  assign m_axi_awprot_o  = 3'b010;
  assign m_axi_awqos_o   = 4'd0;
  assign m_axi_awvalid_o = (state_q == S_ADDR);

  assign m_axi_wdata_o  = s_data_i;
  assign m_axi_wstrb_o  = s_strb_i;
  assign m_axi_wvalid_o = (state_q == S_DATA) && s_valid_i;
  assign m_axi_wlast_o  = (state_q == S_DATA) && (beat_cnt_q == 8'd0);
  assign s_ready_o      = (state_q == S_DATA) && m_axi_wready_i;

  assign m_axi_bready_o = (state_q == S_RESP);

endmodule

// File: tb/tb_dma_axi_w_burst.sv
// tb/tb_dma_axi_w_burst.sv - self-checking bench for dma_axi_w_burst
// Table-driven and random transfers against an AXI slave/stream model and a burst-split reference.
module tb_dma_axi_w_burst;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] start_addr;
  logic [15:0] xfer_beats;
  logic        busy, done, error;
  logic        s_valid;
  logic [31:0] s_data;
  logic [3:0]  s_strb;
  logic        s_ready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic [3:0]  awqos;
  logic        awvalid, awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast, wvalid, wready;
  logic [1:0]  bresp;
  logic        bvalid, bready;

  dma_axi_w_burst #(.DMA_DATA_W(32), .ADDR_W(32), .XFER_W(16), .MAX_BURST_LEN(16)) dut (
    .clk(clk), .rst(rst),
    .start_i(start), .start_addr_i(start_addr), .xfer_beats_i(xfer_beats),
    .busy_o(busy), .done_o(done), .error_o(error),
    .s_valid_i(s_valid), .s_data_i(s_data), .s_strb_i(s_strb), .s_ready_o(s_ready),
    .m_axi_awid_o(awid), .m_axi_awaddr_o(awaddr), .m_axi_awlen_o(awlen),
    .m_axi_awsize_o(awsize), .m_axi_awburst_o(awburst), .m_axi_awlock_o(awlock),
    .m_axi_awcache_o(awcache), .m_axi_awprot_o(awprot), .m_axi_awqos_o(awqos),
    .m_axi_awvalid_o(awvalid), .m_axi_awready_i(awready),
    .m_axi_wdata_o(wdata), .m_axi_wstrb_o(wstrb), .m_axi_wlast_o(wlast),
    .m_axi_wvalid_o(wvalid), .m_axi_wready_i(wready),
    .m_axi_bresp_i(bresp), .m_axi_bvalid_i(bvalid), .m_axi_bready_o(bready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  logic [31:0] src_data [0:1023];
  logic [3:0]  src_strb [0:1023];
  int          src_n, src_idx;
  logic [31:0] aw_addr_q [$];
  logic [7:0]  aw_len_q [$];
  logic [31:0] w_data_q [$];
  logic [3:0]  w_strb_q [$];
  bit          w_last_q [$];
  int          b_n, done_cnt, bad_idx, stab_err, wcopy_err;
  bit          b_pending, stall, mon_en, aw_wait;
  logic [31:0] hold_addr;
  logic [7:0]  hold_len;

  // Slave and stream source: drive on the falling edge, observe the handshake the next rising edge will see.
  initial begin
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        s_valid = 0; awready = 0; wready = 0; bvalid = 0; bresp = 2'b00;
        continue;
      end
      s_valid = (src_idx < src_n) && (!stall || $urandom_range(0, 3) != 0);
      s_data  = src_data[src_idx];
      s_strb  = src_strb[src_idx];
      awready = !stall || $urandom_range(0, 2) == 0;
      wready  = !stall || $urandom_range(0, 3) != 0;
      bvalid  = b_pending && (!stall || $urandom_range(0, 1) == 1);
      bresp   = (b_n == bad_idx) ? 2'b10 : 2'b00;
      #1;
      if (awvalid) begin
        if (aw_wait && (awaddr !== hold_addr || awlen !== hold_len)) stab_err++;
        if (awready) begin
          aw_addr_q.push_back(awaddr);
          aw_len_q.push_back(awlen);
          aw_wait = 0;
        end else begin
          aw_wait = 1; hold_addr = awaddr; hold_len = awlen;
        end
      end
      if (wvalid && (wdata !== s_data || wstrb !== s_strb || s_ready !== wready)) wcopy_err++;
      if (wvalid && wready) begin
        w_data_q.push_back(wdata);
        w_strb_q.push_back(wstrb);
        w_last_q.push_back(wlast);
        src_idx++;
        if (wlast) b_pending = 1;
      end
      if (bvalid && bready) begin
        b_pending = 0;
        b_n++;
      end
      if (done) done_cnt++;
    end
  end

  task automatic prepare(input int n, input bit st, input int bad);
    for (int i = 0; i < n; i++) begin
      src_data[i] = $urandom;
      src_strb[i] = 4'($urandom);
    end
    src_n = n; src_idx = 0;
    aw_addr_q.delete(); aw_len_q.delete();
    w_data_q.delete(); w_strb_q.delete(); w_last_q.delete();
    b_n = 0; done_cnt = 0; stab_err = 0; wcopy_err = 0;
    b_pending = 0; aw_wait = 0;
    stall = st; bad_idx = bad; mon_en = 1;
  endtask

  // exp_bursts < 0: no table value; exp_err < 0: derive from the reference split.
  task automatic run_xfer(input logic [31:0] a, input int n, input bit st, input int bad,
                          input int exp_bursts, input int exp_err, input bit poke, input string tag);
    logic [31:0] m_addr [$];
    int          m_len [$];
    bit          m_last [$];
    logic [31:0] ma;
    int          rem, pg, l, k, mism, cyc;
    bit          eerr;
    ma = a; rem = n;
    while (rem > 0) begin
      pg = (4096 - int'(ma[11:0])) / 4;
      l = (rem < 16) ? rem : 16;
      if (l > pg) l = pg;
      m_addr.push_back(ma);
      m_len.push_back(l);
      for (int j = 0; j < l; j++) m_last.push_back(j == l - 1);
      ma = ma + 32'(l * 4);
      rem -= l;
    end
    eerr = (exp_err >= 0) ? (exp_err != 0) : (bad >= 0 && bad < m_addr.size());

    prepare(n, st, bad);
    @(negedge clk);
    start = 1; start_addr = a; xfer_beats = 16'(n);
    @(negedge clk);
    start = 0;
    #2;
    check({tag, ":busy_after_start"}, busy, 1);
    for (cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      #2;
      if (poke && cyc == 4) begin
        start = 1; start_addr = 32'h9000; xfer_beats = 16'd3;
      end else begin
        start = 0;
      end
      if (done_cnt > 0) break;
    end
    start = 0;
    check({tag, ":timeout"}, cyc < 4000, 1);
    repeat (4) @(negedge clk);
    #2;
    check({tag, ":done_count"}, done_cnt, 1);
    check({tag, ":aw_count"}, aw_addr_q.size(), m_addr.size());
    if (exp_bursts >= 0) check({tag, ":aw_count_tbl"}, aw_addr_q.size(), exp_bursts);
    k = (aw_addr_q.size() < m_addr.size()) ? aw_addr_q.size() : m_addr.size();
    mism = 0;
    for (int i = 0; i < k; i++)
      if (aw_addr_q[i] !== m_addr[i] || int'(aw_len_q[i]) != m_len[i] - 1) mism++;
    check({tag, ":aw_addr_len"}, mism, 0);
    check({tag, ":beats"}, w_data_q.size(), n);
    k = (w_data_q.size() < n) ? w_data_q.size() : n;
    mism = 0;
    for (int i = 0; i < k; i++)
      if (w_data_q[i] !== src_data[i] || w_strb_q[i] !== src_strb[i]) mism++;
    check({tag, ":data_order"}, mism, 0);
    mism = 0;
    for (int i = 0; i < k; i++) if (w_last_q[i] != m_last[i]) mism++;
    check({tag, ":wlast"}, mism, 0);
    check({tag, ":aw_stable"}, stab_err, 0);
    check({tag, ":w_copy"}, wcopy_err, 0);
    check({tag, ":error"}, error, eerr);
    check({tag, ":busy_end"}, busy, 0);
  endtask

  typedef struct {
    logic [31:0] addr;
    int          beats;
    bit          stall;
    int          bad;
    int          exp_bursts;
    int          exp_err;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int cyc;
    vecs[0] = '{32'h0000_1000, 40, 0, -1, 3, 0};
    vecs[1] = '{32'h0000_0FF0,  8, 0, -1, 2, 0};
    vecs[2] = '{32'h0000_2000, 33, 1, -1, 3, 0};
    vecs[3] = '{32'h0000_3000, 48, 1,  1, 3, 1};
    vecs[4] = '{32'h0000_4000, 20, 0, -1, 2, 0};
    vecs[5] = '{32'h0000_0FFC,  1, 1, -1, 1, 0};
    vecs[6] = '{32'h0000_0FC0, 40, 1, -1, 3, 0};
    vecs[7] = '{32'hFFFF_FFF8,  4, 0, -1, 2, 0};

    rst = 1; start = 0; start_addr = 0; xfer_beats = 0; mon_en = 0;
    s_valid = 0; s_data = 0; s_strb = 0; awready = 0; wready = 0; bvalid = 0; bresp = 0;
    src_n = 0; src_idx = 0;
    repeat (3) @(negedge clk);
    #2;
    check("reset_outputs", {busy, done, error, awvalid, wvalid, wlast, bready}, 7'b0);
    rst = 0;

    for (int i = 0; i < 8; i++)
      run_xfer(vecs[i].addr, vecs[i].beats, vecs[i].stall, vecs[i].bad,
               vecs[i].exp_bursts, vecs[i].exp_err, 0, $sformatf("vec%0d", i));

    for (int i = 0; i < 6; i++)
      run_xfer({$urandom} & 32'hFFFF_FFFC, $urandom_range(1, 70), 1'($urandom_range(0, 1)),
               $urandom_range(0, 5) - 1, -1, -1, 0, $sformatf("rnd%0d", i));

    // Error sticks past done, then a zero-length start clears it with a lone done pulse.
    run_xfer(32'h6000, 48, 0, 1, 3, 1, 0, "err");
    prepare(0, 0, -1);
    @(negedge clk);
    #2;
    check("err_sticky", error, 1);
    start = 1; start_addr = 32'h8000; xfer_beats = 0;
    @(negedge clk);
    start = 0;
    #2;
    check("zero:done", done, 1);
    check("zero:busy", busy, 0);
    check("zero:error_cleared", error, 0);
    @(negedge clk);
    #2;
    check("zero:done_one_cycle", done, 0);
    repeat (5) @(negedge clk);
    check("zero:no_aw", aw_addr_q.size(), 0);

    run_xfer(32'h7000, 20, 1, -1, 2, 0, 1, "poke");

    prepare(40, 0, -1);
    @(negedge clk);
    start = 1; start_addr = 32'h5000; xfer_beats = 16'd40;
    @(negedge clk);
    start = 0;
    for (cyc = 0; cyc < 200; cyc++) begin
      @(negedge clk);
      #2;
      if (w_data_q.size() >= 3) break;
    end
    check("rst:reach_data", cyc < 200, 1);
    check("rst:in_data", wvalid, 1);
    mon_en = 0;
    rst = 1;
    #1;
    check("rst:outputs", {busy, done, error, awvalid, wvalid, wlast, bready}, 7'b0);
    @(negedge clk);
    rst = 0;
    run_xfer(32'h5000, 40, 1, -1, 3, 0, 0, "after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
